dac_sample_driver: RTL and testbench
====================================

// Module: dac_sample_driver
// PURPOSE
//   Sample-side companion to the FG/DAC clock divider: accepts function-generator
//   samples on a valid/ready stream, buffers them in a small FIFO and drives the
//   parallel DAC bus plus a generated DAC clock, all from PLL_CLK.
//   Data changes on the falling edge of Dac_CLK, giving a half-period of setup
//   before the DAC samples on the rising edge.
//   Sits between the DDS phase/amplitude pipeline and the DAC pins.
// PARAMETERS
//   DATA_W  10  DAC sample width (bits)
//   DEPTH    8  FIFO depth (entries); power of two, >=2
//   DIV      4  Dac_CLK period in PLL_CLK cycles; even, >=2
//   PRIME    4  FIFO level required to leave IDLE; 1..DEPTH
// PORTS
//   PLL_CLK     in   1           sole clock, all logic on posedge
//   RESET       in   1           synchronous, active-high
//   ENABLE      in   1           run request
//   S_DATA      in   DATA_W      sample from function generator
//   S_VALID     in   1           S_DATA valid
//   S_READY     out  1           FIFO can accept (level < DEPTH)
//   Dac_CLK     out  1           generated DAC clock, registered
//   Dac_DATA    out  DATA_W      DAC bus, offset binary, registered
//   UNDERFLOW   out  1           sticky: a load occurred with FIFO empty
//   FIFO_LEVEL  out  clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//   Reset (sync): FIFO empty, cnt=0, state=IDLE, Dac_CLK=0,
//     Dac_DATA=MID=2^(DATA_W-1), UNDERFLOW=0, S_READY=1.
//   Push: S_VALID&&S_READY at posedge; S_READY combinational = (level<DEPTH).
//   Push and pop in same cycle: level unchanged, both take effect; when full,
//     S_READY=0 even if a pop occurs that cycle.
//   FSM IDLE: cnt held 0, Dac_CLK=0, Dac_DATA=MID, no pops.
//     IDLE->RUN when ENABLE && level>=PRIME; cnt starts counting next cycle.
//   FSM RUN: cnt increments 0..DIV-1 and wraps.
//     cnt==DIV/2-1: next cycle Dac_CLK<=1.
//     cnt==DIV-1 (load tick): next cycle Dac_CLK<=0 and FIFO pops into Dac_DATA.
//       If empty at load tick: Dac_DATA holds, UNDERFLOW<=1, state stays RUN.
//     First falling edge/load occurs DIV cycles after entering RUN.
//   ENABLE low in RUN: current period completes; at the load tick,
//     no pop, Dac_DATA<=MID, Dac_CLK<=0, ->IDLE.
//   UNDERFLOW clears only on RESET.
//   RESET mid-period: all outputs return to reset values next cycle; FIFO
//     contents discarded.
//   Latency: a sample pushed into an empty FIFO while in RUN reaches Dac_DATA
//     at the next load tick (<=DIV cycles).
// CONFIGURATION
//   OFFSET_BINARY_EN defined: S_DATA is two's complement; MSB inverted on pop
//     (0 -> MID, -2^(DATA_W-1) -> 0).
//   Undefined: S_DATA is already offset binary; passed through unchanged.
//   MID reset/idle value identical in both builds.
// TESTING
//   1 Reset, DIV=4, push 4 samples 0x100..0x103 -> RUN; Dac_CLK 2 high/2 low;
//     Dac_DATA=0x100,0x101,... each change coincides with Dac_CLK 1->0.
//   2 Push 8 without pops (ENABLE=0) -> level=8, S_READY=0; 9th S_VALID ignored,
//     level stays 8.
//   3 RUN, stop pushing -> after FIFO drains, next load tick sets UNDERFLOW=1;
//     Dac_DATA holds last value; Dac_CLK keeps toggling.
//   4 Push/pop same cycle at level 3 -> level stays 3; data order preserved.
//   5 OFFSET_BINARY_EN: push 0x000, 0x3FF, 0x200 -> Dac_DATA=0x200, 0x1FF, 0x000;
//     without macro: 0x000, 0x3FF, 0x200.
//   6 ENABLE=0 mid-period -> Dac_CLK completes period, Dac_DATA=0x200, IDLE;
//     RESET mid-RUN -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/dac_sample_driver_if.sv
// Sample stream from the DDS pipeline into the DAC driver (data/valid/ready).
// Latency: none, wires only.
// Backpressure: S_READY low stalls the source. Transfer happens when S_VALID && S_READY at a clock edge.
interface dac_sample_driver_if #(
    parameter int DATA_W = 10
);
    logic [DATA_W-1:0] S_DATA;
    logic              S_VALID;
    logic              S_READY;

    // Function-generator side drives data/valid and observes ready.
    modport master (
        output S_DATA,
        output S_VALID,
        input  S_READY
    );

    // DAC driver side consumes data/valid and drives ready.
    modport slave (
        input  S_DATA,
        input  S_VALID,
        output S_READY
    );
endinterface

// File: rtl/dac_sample_driver.sv
// Buffers DDS samples in a small FIFO and drives the DAC bus plus a generated Dac_CLK from PLL_CLK.
// Latency: a sample reaches Dac_DATA at the next load tick (<= DIV cycles once running, DIV after leaving IDLE).
// Backpressure: S_READY = level < DEPTH. Build option OFFSET_BINARY_EN converts two's-complement input to offset binary.
module dac_sample_driver #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8,
    parameter int DIV    = 4,
    parameter int PRIME  = 4
) (
    input  logic                    PLL_CLK,
    input  logic                    RESET,
    input  logic                    ENABLE,
    dac_sample_driver_if.slave      s_if,
    output logic                    Dac_CLK,
    output logic [DATA_W-1:0]       Dac_DATA,
    output logic                    UNDERFLOW,
    output logic [$clog2(DEPTH):0]  FIFO_LEVEL
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(DIV);

    // Mid-scale code: the DAC rests here in IDLE and after reset.
    localparam logic [DATA_W-1:0] MID       = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [CW-1:0]     CNT_HALF  = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(DIV - 1);
    localparam logic [LW-1:0]     LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0]     LVL_PRIME = LW'(PRIME);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              dac_clk_q, dac_clk_d;
    logic [DATA_W-1:0] dac_data_q, dac_data_d;
    logic              underflow_q, underflow_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [LW-1:0]     level;
    logic              fifo_rdy;
    logic              push;
    logic              pop;
    logic              load_tick;
    logic              half_tick;
    logic [DATA_W-1:0] head_sample;

    // Input coding: optionally flip the MSB to turn two's complement into offset binary.
    function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
`ifdef OFFSET_BINARY_EN
        return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
        return s;
`endif
    endfunction

    // Occupancy and handshake. Ready ignores a same-cycle pop, so a full FIFO always stalls the source.
    assign level       = wr_ptr_q - rd_ptr_q;
    assign fifo_rdy    = (level < LVL_FULL);
    assign push        = s_if.S_VALID && fifo_rdy;
    assign head_sample = mem_q[rd_ptr_q[AW-1:0]];

    // Period phase decode. The load tick is the last PLL_CLK cycle of each Dac_CLK period.
    assign half_tick = (state_q == ST_RUN) && (cnt_q == CNT_HALF);
    assign load_tick = (state_q == ST_RUN) && (cnt_q == CNT_LAST);

    // Sample storage. Not reset, because a reset empties the FIFO through its pointers.
    always_ff @(posedge PLL_CLK) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= s_if.S_DATA;
        end
    end

    // FIFO pointer next-state. A push and a pop in the same cycle both take effect.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + LW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LW'(1);
        end
    end

    // Sequencer next-state: divider count, DAC clock, DAC data, sticky underflow and pop request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dac_clk_d   = dac_clk_q;
        dac_data_d  = dac_data_q;
        underflow_d = underflow_q;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d      = '0;
                dac_clk_d  = 1'b0;
                dac_data_d = MID;
                // Wait for enough samples to ride out start-up jitter from the source.
                if (ENABLE && (level >= LVL_PRIME)) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                cnt_d = load_tick ? '0 : cnt_q + CW'(1);

                if (half_tick) begin
                    dac_clk_d = 1'b1;
                end

                if (load_tick) begin
                    // Data moves with the falling Dac_CLK edge, giving the DAC a half period of setup.
                    dac_clk_d = 1'b0;
                    if (!ENABLE) begin
                        // A stop request only takes effect here, so the last period always completes.
                        dac_data_d = MID;
                        state_d    = ST_IDLE;
                    end else if (level != '0) begin
                        pop        = 1'b1;
                        dac_data_d = to_dac(head_sample);
                    end else begin
                        // Starved: keep the last code on the bus and flag it until the next reset.
                        underflow_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset. Reset discards FIFO contents and parks the DAC at mid-scale.
    always_ff @(posedge PLL_CLK) begin
        if (RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dac_clk_q   <= 1'b0;
            dac_data_q  <= MID;
            underflow_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dac_clk_q   <= dac_clk_d;
            dac_data_q  <= dac_data_d;
            underflow_q <= underflow_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    assign s_if.S_READY = fifo_rdy;
    assign Dac_CLK      = dac_clk_q;
    assign Dac_DATA     = dac_data_q;
    assign UNDERFLOW    = underflow_q;
    assign FIFO_LEVEL   = level;

endmodule

// File: tb/tb_dac_sample_driver.sv
// Scoreboard bench for dac_sample_driver with default parameters (DATA_W=10, DEPTH=8, DIV=4, PRIME=4).
// Expected Dac_DATA values are queued as samples are pushed. A monitor pops one value on every falling Dac_CLK edge.
// Inputs change on negedge, and everything is sampled 1ns after posedge.
module tb_dac_sample_driver;

    localparam int          DATA_W = 10;
    localparam int          DIV    = 4;
    localparam logic [9:0]  MID    = 10'h200;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       dac_clk;
    logic [9:0] dac_data;
    logic       uflow;
    logic [3:0] lvl;

    int checks   = 0;
    int failures = 0;
    logic [9:0] exp_q [$];

    always #5 clk = ~clk;

    dac_sample_driver_if #(.DATA_W(DATA_W)) s_if ();

    dac_sample_driver dut (
        .PLL_CLK    (clk),
        .RESET      (rst),
        .ENABLE     (en),
        .s_if       (s_if),
        .Dac_CLK    (dac_clk),
        .Dac_DATA   (dac_data),
        .UNDERFLOW  (uflow),
        .FIFO_LEVEL (lvl)
    );

    // Expected DAC code for a pushed sample under the active build option.
    function automatic logic [9:0] xf(input logic [9:0] s);
`ifdef OFFSET_BINARY_EN
        return {~s[9], s[8:0]};
`else
        return s;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Wait for n falling Dac_CLK edges, with a cycle budget. cyc returns the number of posedges consumed.
    task automatic wait_fall(input int n, input string name, output int cyc);
        logic pc;
        int   got;
        pc  = dac_clk;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (pc && !dac_clk) got++;
            pc = dac_clk;
        end
        checks++;
        if (got < n) begin
            failures++;
            $display("FAIL %s timeout actual_falls=%0d expected_falls=%0d", name, got, n);
        end
    endtask

    // Monitor: every non-reset Dac_CLK fall must match the queue head, and Dac_DATA must not change elsewhere.
    initial begin : monitor
        logic       pc;
        logic [9:0] pd;
        logic [9:0] e;
        pc = 1'b0;
        pd = MID;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (pc && !dac_clk) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL dac_fall_unexpected actual=0x%0h expected=none", dac_data);
                    end else begin
                        e = exp_q.pop_front();
                        if (dac_data !== e) begin
                            failures++;
                            $display("FAIL dac_data_at_fall actual=0x%0h expected=0x%0h", dac_data, e);
                        end
                    end
                end else if (dac_data !== pd) begin
                    checks++;
                    failures++;
                    $display("FAIL dac_data_off_fall actual=0x%0h expected=0x%0h", dac_data, pd);
                end
            end
            pc = dac_clk;
            pd = dac_data;
        end
    end

    initial begin : stimulus
        logic [9:0] vals [4];
        logic       pat  [8];
        int         cyc;
        int         w;

        rst = 1'b1;
        en  = 1'b0;
        s_if.S_VALID = 1'b0;
        s_if.S_DATA  = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dac_clk",  dac_clk,      0);
        chk("reset_dac_data", dac_data,     MID);
        chk("reset_underflow", uflow,       0);
        chk("reset_level",    lvl,          0);
        chk("reset_ready",    s_if.S_READY, 1);

        // Fill to DEPTH with ENABLE low. A 9th valid beat must be refused.
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s_if.S_VALID = 1'b1;
            s_if.S_DATA  = 10'(i);
        end
        @(negedge clk);
        chk("full_level", lvl,          8);
        chk("full_ready", s_if.S_READY, 0);
        s_if.S_DATA = 10'h3AA;
        @(negedge clk);
        chk("full_level_hold", lvl, 8);
        s_if.S_VALID = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("flush_level", lvl,          0);
        chk("flush_ready", s_if.S_READY, 1);

        // Prime with 0x100..0x103, then run. First fall comes DIV cycles after the RUN entry edge.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_if.S_VALID = 1'b1;
            s_if.S_DATA  = 10'h100 + 10'(i);
            exp_q.push_back(xf(10'h100 + 10'(i)));
        end
        @(negedge clk);
        s_if.S_VALID = 1'b0;
        chk("primed_level",    lvl,      4);
        chk("idle_data_mid",   dac_data, MID);
        en = 1'b1;
        wait_fall(1, "first_load", cyc);
        chk("first_load_latency", cyc, DIV + 1);

        // Dac_CLK shape starting at a fall: 2 low, 2 high.
        pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk("dac_clk_pattern", dac_clk, pat[k]);
        end

        // Drain. The load after the last sample underflows and holds 0x103.
        wait_fall(2, "drain", cyc);
        chk("no_underflow_yet", uflow, 0);
        repeat (3) exp_q.push_back(xf(10'h103));
        wait_fall(1, "underflow_load", cyc);
        chk("underflow_set",   uflow, 1);
        chk("underflow_level", lvl,   0);
        wait_fall(1, "clk_keeps_running", cyc);

        // Refill 3 samples, then push the 4th on the load cycle. Level must stay 3.
        vals = '{10'h000, 10'h3FF, 10'h200, 10'h155};
        repeat (4) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_if.S_VALID = 1'b1;
            s_if.S_DATA  = vals[i];
            exp_q.push_back(xf(vals[i]));
        end
        @(negedge clk);
        chk("pushpop_level", lvl, 3);
        s_if.S_VALID = 1'b0;
        wait_fall(3, "drain_pushpop", cyc);

        // Drop ENABLE mid-period. The period completes, then the bus returns to MID and the block idles.
        exp_q.push_back(MID);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        chk("stop_clk_completes", dac_clk, 1);
        wait_fall(1, "stop_fall", cyc);
        chk("stop_fall_latency", cyc, 2);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk("idle_clk_low", dac_clk,  0);
            chk("idle_mid",     dac_data, MID);
        end
        chk("underflow_sticky", uflow, 1);

        // Reset in the middle of a RUN period.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_if.S_VALID = 1'b1;
            s_if.S_DATA  = 10'h2F0 + 10'(i);
        end
        @(negedge clk);
        s_if.S_VALID = 1'b0;
        en = 1'b1;
        w = 0;
        while (dac_clk !== 1'b1 && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("rerun_clk_high", dac_clk, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_reset_clk",       dac_clk,      0);
        chk("midrun_reset_data",      dac_data,     MID);
        chk("midrun_reset_underflow", uflow,        0);
        chk("midrun_reset_level",     lvl,          0);
        chk("midrun_reset_ready",     s_if.S_READY, 1);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("post_reset_idle_clk", dac_clk, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
